run_length_detector: RTL



---
 rtl/run_length_detector_pkg.sv | 28 ++
 rtl/sat_event_counter.sv | 33 +++
 rtl/run_length_detector.sv | 132 +++++++++++++
 3 files changed

// File: rtl/run_length_detector_pkg.sv
// Shared types and mode constants for the run-length detector and its helpers.
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DETECT = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BOTH  = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  // Whether a run of bit_val is reportable under the given mode.
  function automatic logic mode_enabled(input logic [1:0] mode, input logic bit_val);
    logic en;
    case (mode)
      MODE_BOTH:  en = 1'b1;
      MODE_ONES:  en = bit_val;
      MODE_ZEROS: en = ~bit_val;
      MODE_OFF:   en = 1'b0;
      default:    en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter with a sticky saturation flag; clear wins over
// holding but a coincident increment still counts as the first new event.
module sat_event_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Counter and sticky flag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {W{1'b0}};
      sat   <= 1'b0;
    end else if (clr) begin
      count <= inc ? W'(1) : {W{1'b0}};
      sat   <= 1'b0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + W'(1);
      sat   <= sat | ((count + W'(1)) == CNT_MAX);
    end else begin
      count <= count;
      sat   <= sat;
    end
  end

endmodule

// File: rtl/run_length_detector.sv
// Detects RUN_LEN consecutive identical qualified bits, gated per bit value
// by mode, and counts one event per detected run.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN        = 4,
  parameter int CNT_W          = 8,
  parameter bit REGISTERED_OUT = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic                           in_x,
  input  logic [1:0]                     mode,
  input  logic                           clr_count,
  output logic                           hit,
  output logic                           hit_val,
  output logic [$clog2(RUN_LEN+1)-1:0]   run_len,
  output logic [CNT_W-1:0]               hit_count,
  output logic                           count_sat
);

  localparam int RL_W = $clog2(RUN_LEN + 1);
  localparam logic [RL_W-1:0] RUN_MAX = RL_W'(RUN_LEN);

  state_t            state_r, state_s;
  logic              last_bit_r, last_bit_s;
  logic [RL_W-1:0]   run_len_r, run_len_s;
  logic              enabled_s;
  logic              hit_s;
  logic              hit_val_s;
  logic              event_s;

  // State, last bit and run length registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      last_bit_r <= 1'b0;
      run_len_r  <= {RL_W{1'b0}};
    end else begin
      state_r    <= state_s;
      last_bit_r <= last_bit_s;
      run_len_r  <= run_len_s;
    end
  end

  // Next-state logic; an unqualified sample leaves everything as it is.
  always_comb begin
    state_s    = state_r;
    last_bit_s = last_bit_r;
    run_len_s  = run_len_r;
    if (in_valid) begin
      case (state_r)
        IDLE: begin
          last_bit_s = in_x;
          run_len_s  = RL_W'(1);
          state_s    = COUNT;
        end
        COUNT, DETECT: begin
          if (in_x == last_bit_r) begin
            if (run_len_r >= RUN_MAX) begin
              run_len_s = RUN_MAX;
            end else begin
              run_len_s = run_len_r + RL_W'(1);
            end
            if (run_len_s == RUN_MAX) begin
              state_s = DETECT;
            end else begin
              state_s = COUNT;
            end
          end else begin
            last_bit_s = in_x;
            run_len_s  = RL_W'(1);
            state_s    = COUNT;
          end
        end
        default: begin
          state_s    = IDLE;
          last_bit_s = 1'b0;
          run_len_s  = {RL_W{1'b0}};
        end
      endcase
    end else begin
      state_s    = state_r;
      last_bit_s = last_bit_r;
      run_len_s  = run_len_r;
    end
  end

  // Mode only gates reporting; the FSM tracks runs of either value regardless.
  assign enabled_s = mode_enabled(mode, last_bit_r);
  assign hit_s     = (state_r == DETECT) && enabled_s;
  assign hit_val_s = hit_s & last_bit_r;
  assign event_s   = (state_r == COUNT) && (state_s == DETECT) && enabled_s;
  assign run_len   = run_len_r;

  generate
    if (REGISTERED_OUT) begin : g_reg_out
      logic hit_r;
      logic hit_val_r;

      // One extra flop of latency on the hit outputs.
      always_ff @(posedge clk) begin
        if (reset) begin
          hit_r     <= 1'b0;
          hit_val_r <= 1'b0;
        end else begin
          hit_r     <= hit_s;
          hit_val_r <= hit_val_s;
        end
      end

      assign hit     = hit_r;
      assign hit_val = hit_val_r;
    end else begin : g_comb_out
      assign hit     = hit_s;
      assign hit_val = hit_val_s;
    end
  endgenerate

  sat_event_counter #(
    .W(CNT_W)
  ) u_hit_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (clr_count),
    .inc  (event_s),
    .count(hit_count),
    .sat  (count_sat)
  );

endmodule
